// File: rtl/sfilt_seq_pkg.sv
// sfilt_pkg: types shared by the filter command sequencer and the serial
// filter block it feeds.
//   cmd_t        - command codes carried on cmd[1:0]
//   seq_state_t  - sequencer FSM states (also exported on dbg_state)
//   shift_word() - formats the shift amount as the h operand of CMD_SHIFT
package sfilt_pkg;

   typedef enum logic [1:0] {
      CMD_FIRST = 2'd0,   // acc = q*h
      CMD_MAC   = 2'd1,   // acc += q*h
      CMD_SHIFT = 2'd2,   // acc >>= h (rounded)
      CMD_OUT   = 2'd3    // emit acc, clear
   } cmd_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CMD0  = 3'd1,
      S_MAC   = 3'd2,
      S_GAP1  = 3'd3,
      S_SHIFT = 3'd4,
      S_GAP2  = 3'd5,
      S_OUT   = 3'd6
   } seq_state_t;

   function automatic logic [31:0] shift_word(input logic [6:0] s);
      return {25'b0, s};
   endfunction

endpackage

// File: rtl/sfilt_seq_if.sv
// sfilt_seq_if: host/filter-side bundle of the filter command sequencer.
//
// Handshake semantics:
//   - A sample on din transfers on a rising clk edge where pushin=1 and
//     stopin=0. stopin is registered (it is the hold-register-full flag),
//     so a source may sample it before the edge and decide to push.
//   - A coefficient write is offered for exactly the cycles cpush=1; it has
//     no back-pressure. A rejected write is reported by a one-cycle cerr
//     pulse in the cycle after the offer.
//   - pushout=1 marks a valid command beat on cmd/q/h. There is no ready:
//     the filter takes every beat. With pushout=0, cmd/q/h hold their last
//     values and carry no meaning.
//
// Modports:
//   slave  - the sequencer (consumes samples/coefficients, produces commands)
//   master - the host/bench side
interface sfilt_seq_if #(
   parameter int NTAPS = 8
);
   localparam int AW = $clog2(NTAPS);

   logic          pushin;
   logic          stopin;
   logic [31:0]   din;
   logic          cpush;
   logic [AW-1:0] caddr;
   logic [31:0]   cdata;
   logic          cerr;
   logic [6:0]    shamt;
   logic          pushout;
   logic [1:0]    cmd;
   logic [31:0]   q;
   logic [31:0]   h;
   logic          busy;

   modport slave (
      input  pushin, din, cpush, caddr, cdata, shamt,
      output stopin, cerr, pushout, cmd, q, h, busy
   );

   modport master (
      output pushin, din, cpush, caddr, cdata, shamt,
      input  stopin, cerr, pushout, cmd, q, h, busy
   );

endinterface

// File: rtl/sfilt_seq_line.sv
// sfilt_seq_line: NTAPS x 32 sample delay line for the command sequencer.
//
// Ports:
//   clk, rst  - clock; asynchronous active-low reset (clears every entry)
//   wr_en     - frame start: store wr_data at wptr and seed the read
//               pointer with the frame's write position
//   wr_data   - the new sample x[n]
//   rd_step   - consume the presented read word and step one tap older
//   wp_adv    - advance the write pointer (once per frame)
//   rd_data   - line[(rd_ptr - 1) mod NTAPS], i.e. the next older sample
//
// NTAPS need not be a power of two, so both pointers wrap by compare
// rather than by masking.
module sfilt_seq_line
   import sfilt_pkg::*;
#(
   parameter  int NTAPS = 8,
   localparam int AW    = $clog2(NTAPS)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   input  logic        rd_step,
   input  logic        wp_adv,
   output logic [31:0] rd_data
);

   localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

   logic [31:0]   line_q [NTAPS];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_addr;

   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
      return (p == LAST) ? '0 : p + AW'(1);
   endfunction

   function automatic logic [AW-1:0] wrap_dec(input logic [AW-1:0] p);
      return (p == '0) ? LAST : p - AW'(1);
   endfunction

   // rd_ptr points at the tap most recently handed out; the word on
   // rd_data is always the one just older than that.
   assign rd_addr = wrap_dec(rd_ptr);
   assign rd_data = line_q[rd_addr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NTAPS; i++) begin
            line_q[i] <= '0;
         end
         wptr   <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            line_q[wptr] <= wr_data;
            rd_ptr       <= wptr;
         end else if (rd_step) begin
            rd_ptr <= rd_addr;
         end
         if (wp_adv) begin
            wptr <= wrap_inc(wptr);
         end
      end
   end

endmodule

// File: rtl/sfilt_seq.sv
// sfilt_seq: command sequencer in front of the serial filter block.
//
// Takes one sample per frame through a one-entry hold register, keeps an
// NTAPS-deep delay line and an NTAPS-entry coefficient RAM, and for every
// sample emits: CMD_FIRST, NTAPS-1 x CMD_MAC, GAP idle cycles, CMD_SHIFT,
// GAP idle cycles, CMD_OUT. A frame lasts NTAPS + 2 + 2*GAP cycles and
// frames run back to back when the next sample is already held.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset; aborts any frame
//   bus        - sfilt_seq_if.slave: pushin/stopin/din sample input,
//                cpush/caddr/cdata/cerr coefficient writes, shamt,
//                pushout/cmd/q/h command stream, busy
//   dbg_state  - current FSM state
module sfilt_seq
   import sfilt_pkg::*;
#(
   parameter int NTAPS = 8,
   parameter int GAP   = 3
) (
   input  logic        clk,
   input  logic        rst,
   sfilt_seq_if.slave  bus,
   output seq_state_t  dbg_state
);

   localparam int            AW       = $clog2(NTAPS);
   localparam logic [AW-1:0] LAST_K   = AW'(NTAPS - 1);
   localparam logic [AW:0]   NTAPS_W  = (AW + 1)'(NTAPS);
   localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   seq_state_t    state, state_d;
   logic [AW-1:0] k, k_d, k_nxt;
   logic [3:0]    gap_cnt, gap_d;

   logic          po_r, po_d;
   cmd_t          cmd_r, cmd_d;
   logic [31:0]   q_r, q_d;
   logic [31:0]   h_r, h_d;

   logic          hold_full;
   logic [31:0]   hold_data;
   logic [6:0]    shamt_q;
   logic          cerr_r;
   logic [31:0]   coef [NTAPS];

   logic          frame_start;
   logic          rd_step;
   logic          wp_adv;
   logic [31:0]   line_rd;
   logic          accept;
   logic          coef_ok;

   assign k_nxt = k + AW'(1);

   // ------------------------------------------------------------------
   // FSM next state. Command outputs are registered: each branch loads
   // the beat that belongs to the state being entered, so pushout/cmd/
   // q/h line up with dbg_state in the same cycle.
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state;
      k_d         = k;
      gap_d       = gap_cnt;
      po_d        = 1'b0;
      cmd_d       = cmd_r;
      q_d         = q_r;
      h_d         = h_r;
      frame_start = 1'b0;
      rd_step     = 1'b0;
      wp_adv      = 1'b0;

      case (state)
         S_IDLE, S_OUT: begin
            if (hold_full) begin
               frame_start = 1'b1;
               state_d     = S_CMD0;
               po_d        = 1'b1;
               cmd_d       = CMD_FIRST;
               q_d         = hold_data;   // x[n] bypasses the line
               h_d         = coef[0];
            end else begin
               state_d = S_IDLE;
            end
         end

         S_CMD0: begin
            rd_step = 1'b1;
            wp_adv  = 1'b1;
            k_d     = AW'(1);
            state_d = S_MAC;
            po_d    = 1'b1;
            cmd_d   = CMD_MAC;
            q_d     = line_rd;
            h_d     = coef[1];
         end

         S_MAC: begin
            if (k == LAST_K) begin
               if (GAP > 0) begin
                  state_d = S_GAP1;
                  gap_d   = GAP_LOAD;
               end else begin
                  state_d = S_SHIFT;
                  po_d    = 1'b1;
                  cmd_d   = CMD_SHIFT;
                  q_d     = '0;
                  h_d     = shift_word(shamt_q);
               end
            end else begin
               rd_step = 1'b1;
               k_d     = k_nxt;
               po_d    = 1'b1;
               cmd_d   = CMD_MAC;
               q_d     = line_rd;
               h_d     = coef[k_nxt];
            end
         end

         S_GAP1: begin
            if (gap_cnt == 4'd0) begin
               state_d = S_SHIFT;
               po_d    = 1'b1;
               cmd_d   = CMD_SHIFT;
               q_d     = '0;
               h_d     = shift_word(shamt_q);
            end else begin
               gap_d = gap_cnt - 4'd1;
            end
         end

         S_SHIFT: begin
            if (GAP > 0) begin
               state_d = S_GAP2;
               gap_d   = GAP_LOAD;
            end else begin
               state_d = S_OUT;
               po_d    = 1'b1;
               cmd_d   = CMD_OUT;
               q_d     = '0;
               h_d     = '0;
            end
         end

         S_GAP2: begin
            if (gap_cnt == 4'd0) begin
               state_d = S_OUT;
               po_d    = 1'b1;
               cmd_d   = CMD_OUT;
               q_d     = '0;
               h_d     = '0;
            end else begin
               gap_d = gap_cnt - 4'd1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         k       <= '0;
         gap_cnt <= '0;
         po_r    <= 1'b0;
         cmd_r   <= CMD_FIRST;
         q_r     <= '0;
         h_r     <= '0;
      end else begin
         state   <= state_d;
         k       <= k_d;
         gap_cnt <= gap_d;
         po_r    <= po_d;
         cmd_r   <= cmd_d;
         q_r     <= q_d;
         h_r     <= h_d;
      end
   end

   // ------------------------------------------------------------------
   // Hold register, shift-amount latch and coefficient RAM.
   // A frame start always finds the hold full, so stopin is 1 in that
   // cycle and acceptance and clearing never coincide.
   // ------------------------------------------------------------------
   assign accept  = bus.pushin && !hold_full;
   assign coef_ok = bus.cpush && (state == S_IDLE) && !frame_start &&
                    ({1'b0, bus.caddr} < NTAPS_W);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_full <= 1'b0;
         hold_data <= '0;
         shamt_q   <= '0;
         cerr_r    <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            coef[i] <= '0;
         end
      end else begin
         if (frame_start) begin
            hold_full <= 1'b0;
            shamt_q   <= bus.shamt;
         end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= bus.din;
         end
         cerr_r <= bus.cpush && !coef_ok;
         if (coef_ok) begin
            coef[bus.caddr] <= bus.cdata;
         end
      end
   end

   sfilt_seq_line #(
      .NTAPS (NTAPS)
   ) u_line (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (frame_start),
      .wr_data (hold_data),
      .rd_step (rd_step),
      .wp_adv  (wp_adv),
      .rd_data (line_rd)
   );

   assign bus.stopin  = hold_full;
   assign bus.cerr    = cerr_r;
   assign bus.pushout = po_r;
   assign bus.cmd     = cmd_r;
   assign bus.q       = q_r;
   assign bus.h       = h_r;
   assign bus.busy    = (state != S_IDLE);
   assign dbg_state   = state;

endmodule

// File: doc/sfilt_seq.md
Name: sfilt_seq

Overview:
- Command sequencer that drives the serial filter block (`cmd`/`q`/`h`/`pushout` on its input side).
- Accepts one 32-bit sample per frame and keeps an NTAPS-deep sample delay line plus a coefficient RAM.
- For each sample it emits the full command stream: first mult, NTAPS-1 mult-accumulates, shift/round, then output/clear.
- Inserts GAP idle cycles before the shift and output commands so the filter pipeline settles.

Parameters:
- NTAPS, 8, number of filter taps (2..64; need not be a power of 2).
- GAP, 3, idle cycles inserted before cmd 2 and before cmd 3 (0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- pushin  input  1  sample valid; accepted when pushin=1 and stopin=0.
- stopin  output  1  hold register full; sample not accepted this cycle.
- din  input  32  sample x[n].
- cpush  input  1  coefficient write strobe.
- caddr  input  $clog2(NTAPS)  coefficient index k.
- cdata  input  32  coefficient c[k].
- cerr  output  1  one-cycle pulse: coefficient write rejected.
- shamt  input  7  right-shift amount; sampled at frame start.
- pushout  output  1  command valid to filter.
- cmd  output  2  filter command code (0..3).
- q  output  32  sample operand.
- h  output  32  coefficient, or zero-extended shift amount for cmd 2.
- busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Reset (rst=0, async):
  - outputs: pushout=0, cmd=0, q=0, h=0, stopin=0, cerr=0, busy=0.
  - internal: delay line and coefficient RAM cleared to 0, write pointer=0, state=IDLE.
  - Reset mid-frame aborts the frame; no further commands are issued.
- Input side:
  - One-entry hold register; stopin = hold full (registered).
  - Hold clears on the cycle a frame starts. A sample offered that cycle is refused because stopin=1.
- Frame start: from IDLE, or directly from OUT, when hold is full. At start:
  - write the hold sample into the delay line at wptr;
  - latch shamt;
  - the next cycle is CMD0.
- States and outputs (all registered; pushout=1 only in the CMD states):
  - IDLE: pushout=0.
  - CMD0: cmd=0, q=x[n], h=c[0]; go to MAC with k=1.
  - MAC: cmd=1, q=x[n-k], h=c[k]; k increments each cycle. After k=NTAPS-1, go to GAP1 (or SHIFT if GAP=0).
  - GAP1: pushout=0 for GAP cycles, then SHIFT.
  - SHIFT: cmd=2, q=0, h={25'b0, shamt_latched}; then GAP2 (or OUT if GAP=0).
  - GAP2: pushout=0 for GAP cycles, then OUT.
  - OUT: cmd=3, q=0, h=0; then CMD0 if hold is full, else IDLE.
- Delay-line addressing:
  - x[n-k] = line[(wptr_frame - k) mod NTAPS], using compare-and-wrap, not power-of-2 masking.
  - wptr advances modulo NTAPS once per frame, after the CMD0 read.
  - Delay-line entries never written read as 0, so the first frames see zero history.
- Frame length: NTAPS + 2 + 2*GAP cycles; 16 at the defaults.
- Latency: sample accepted at cycle t from IDLE → hold full at t+1, frame start at t+1, CMD0 pushout at t+2.
- Coefficient writes:
  - Accepted only in IDLE, and only when no frame starts that cycle.
  - Otherwise the write is ignored and cerr pulses one cycle.
  - caddr >= NTAPS is ignored with a cerr pulse.
- When pushout=0: cmd/q/h hold their last values; the filter ignores them.
- Simultaneous sample acceptance and cpush in IDLE: the sample is accepted; the write is accepted if no frame starts that cycle.

Decomposition:
- Shared package sfilt_pkg:
  - command codes CMD_FIRST=0, CMD_MAC=1, CMD_SHIFT=2, CMD_OUT=3 (typedef cmd_t), shared with the filter block;
  - state enum seq_state_t.
- One natural sub-module: sfilt_seq_line, the NTAPS×32 delay line with write pointer and modulo read address.
- Coefficient RAM and the FSM stay in the top.

Test Plan:
- Reset, then write c[k]=k+1 for k=0..7, shamt=0, push din=5.
  - Expect cmd 0,1×7, gap×3, 2, gap×3, 3.
  - Expect q=5 with h=1 on cmd 0, then q=0 with h=2..8 on cmd 1.
  - Expect total span of 16 cycles, CMD0 two cycles after the push.
- Push samples 1,2,...,10 back-to-back with stopin honoured.
  - Frames are contiguous (OUT→CMD0, no IDLE between).
  - In frame 10, the cmd-1 q values are 9,8,...,3 (wrap verified).
- cpush while busy=1 → cerr pulse, RAM unchanged.
  - Read back: next frame's h values equal the previous ones.
- cpush with caddr=9 when NTAPS=10 accepted; shamt=7'd20 → SHIFT beat h=32'd20.
- Assert rst=0 asynchronously during a MAC beat → pushout=0 immediately.
  - After release, the first frame uses all-zero history and coefficients (h=0 on every beat).
- GAP=0 build, NTAPS=2 → sequence cmd 0,1,2,3 in four consecutive cycles, with no gaps.
